// File: rtl/load_unit.sv
// Load path between the memory stage and a word-wide data-memory port: issues one or
// two aligned reads per request, then extracts and sign/zero-extends the addressed bytes.
module load_unit #(
    parameter int unsigned XLEN           = 32,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_valid,
    output logic            O_ready,
    input  logic [2:0]      I_loadsel,
    input  logic [XLEN-1:0] I_addr,
    output logic            O_mem_req,
    output logic [XLEN-1:0] O_mem_addr,
    input  logic            I_mem_ack,
    input  logic [XLEN-1:0] I_mem_data,
    output logic            O_valid,
    output logic [XLEN-1:0] O_data,
    output logic            O_misaligned
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(BYTES - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_REQ1,
        S_RESP,
        S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] data_q, data_d;

    logic [XLEN-1:0] base;
    logic [OFFW-1:0] off;
    logic            crossing;
    logic            misaligned_in;

    // Access size in bytes; a doubleword collapses to a word when XLEN is 32.
    function automatic logic [3:0] size_of(input logic [2:0] sel);
        case (sel[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return (XLEN == 64) ? 4'd8 : 4'd4;
        endcase
    endfunction

    function automatic logic [OFFW-1:0] align_bits(input logic [2:0] sel);
        case (sel[1:0])
            2'b00:   return '0;
            2'b01:   return OFFW'(1);
            2'b10:   return OFFW'(3);
            default: return '1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] hi,
                                                input logic [XLEN-1:0] lo,
                                                input logic [2:0]      sel,
                                                input logic [OFFW-1:0] sh);
        logic [XLEN-1:0] win;
        logic [XLEN-1:0] keep;
        logic            sbit;
        win = XLEN'({hi, lo} >> {sh, 3'b000});
        case (sel[1:0])
            2'b00:   begin keep = XLEN'(8'hFF);         sbit = win[7];      end
            2'b01:   begin keep = XLEN'(16'hFFFF);      sbit = win[15];     end
            2'b10:   begin keep = XLEN'(32'hFFFF_FFFF); sbit = win[31];     end
            default: begin keep = '1;                   sbit = win[XLEN-1]; end
        endcase
        sbit = sbit & ~sel[2];
        return (win & keep) | ({XLEN{sbit}} & ~keep);
    endfunction

    assign base          = addr_q & ALIGN_MASK;
    assign off           = addr_q[OFFW-1:0];
    assign crossing      = (32'(off) + 32'(size_of(sel_q))) > BYTES;
    assign misaligned_in = (I_addr[OFFW-1:0] & align_bits(I_loadsel)) != '0;
    assign O_data        = data_q;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            lo_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        lo_d         = lo_q;
        data_d       = data_q;
        O_ready      = 1'b0;
        O_mem_req    = 1'b0;
        O_mem_addr   = '0;
        O_valid      = 1'b0;
        O_misaligned = 1'b0;

        case (state_q)
            S_IDLE: begin
                O_ready = 1'b1;
                if (I_valid) begin
                    sel_d  = I_loadsel;
                    addr_d = I_addr;
                    if (misaligned_in && !MISALIGN_SPLIT) begin
                        state_d = S_ERR;
                        data_d  = '0;
                    end else begin
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: begin
                O_mem_req  = 1'b1;
                O_mem_addr = base;
                if (I_mem_ack) begin
                    lo_d = I_mem_data;
                    if (crossing) begin
                        state_d = S_REQ1;
                    end else begin
                        // Non-crossing bytes all sit in this word, so the upper half is a don't-care.
                        data_d  = extract(I_mem_data, I_mem_data, sel_q, off);
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ1: begin
                O_mem_req  = 1'b1;
                O_mem_addr = base + XLEN'(BYTES);
                if (I_mem_ack) begin
                    data_d  = extract(I_mem_data, lo_q, sel_q, off);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                O_valid = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                O_valid      = 1'b1;
                O_misaligned = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: three instances (32-bit split, 32-bit flagging, 64-bit split)
// checked against a byte-addressed memory model.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dut_sel = 2'd0;
    logic        tb_valid = 1'b0;
    logic        tb_ack = 1'b0;
    logic [2:0]  tb_sel = '0;
    logic [63:0] tb_addr = '0;
    logic [63:0] tb_mdata = '0;

    logic        r0, r1, r2, q0, q1, q2, v0, v1, v2, m0, m1, m2;
    logic [31:0] ma0, ma1, d0, d1;
    logic [63:0] ma2, d2;

    logic        ob_ready, ob_mem_req, ob_valid, ob_mis;
    logic [63:0] ob_mem_addr, ob_data;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  bm [logic [63:0]];

    always #5 clk = ~clk;

    load_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) u_s32 (
        .I_clk(clk), .I_rst(rst), .I_valid(tb_valid && dut_sel == 2'd0), .O_ready(r0),
        .I_loadsel(tb_sel), .I_addr(tb_addr[31:0]), .O_mem_req(q0), .O_mem_addr(ma0),
        .I_mem_ack(tb_ack && dut_sel == 2'd0), .I_mem_data(tb_mdata[31:0]),
        .O_valid(v0), .O_data(d0), .O_misaligned(m0));

    load_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) u_n32 (
        .I_clk(clk), .I_rst(rst), .I_valid(tb_valid && dut_sel == 2'd1), .O_ready(r1),
        .I_loadsel(tb_sel), .I_addr(tb_addr[31:0]), .O_mem_req(q1), .O_mem_addr(ma1),
        .I_mem_ack(tb_ack && dut_sel == 2'd1), .I_mem_data(tb_mdata[31:0]),
        .O_valid(v1), .O_data(d1), .O_misaligned(m1));

    load_unit #(.XLEN(64), .MISALIGN_SPLIT(1'b1)) u_s64 (
        .I_clk(clk), .I_rst(rst), .I_valid(tb_valid && dut_sel == 2'd2), .O_ready(r2),
        .I_loadsel(tb_sel), .I_addr(tb_addr), .O_mem_req(q2), .O_mem_addr(ma2),
        .I_mem_ack(tb_ack && dut_sel == 2'd2), .I_mem_data(tb_mdata),
        .O_valid(v2), .O_data(d2), .O_misaligned(m2));

    always_comb begin
        case (dut_sel)
            2'd0: begin
                ob_ready = r0; ob_mem_req = q0; ob_mem_addr = 64'(ma0);
                ob_valid = v0; ob_data = 64'(d0); ob_mis = m0;
            end
            2'd1: begin
                ob_ready = r1; ob_mem_req = q1; ob_mem_addr = 64'(ma1);
                ob_valid = v1; ob_data = 64'(d1); ob_mis = m1;
            end
            default: begin
                ob_ready = r2; ob_mem_req = q2; ob_mem_addr = ma2;
                ob_valid = v2; ob_data = d2; ob_mis = m2;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [31:0] h;
        if (bm.exists(a)) return bm[a];
        h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
        return h[20:13];
    endfunction

    task automatic put_bytes(input logic [63:0] a, input logic [63:0] val, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) bm[a + 64'(i)] = val[8*i +: 8];
    endtask

    function automatic int unsigned cur_bytes();
        return (dut_sel == 2'd2) ? 8 : 4;
    endfunction

    function automatic logic [63:0] cur_mask();
        return (dut_sel == 2'd2) ? '1 : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w = '0;
        for (int unsigned i = 0; i < cur_bytes(); i++)
            w[8*i +: 8] = mem_byte((a + 64'(i)) & cur_mask());
        return w;
    endfunction

    // One full load on the selected instance: model expectation, handshake, memory replies.
    task automatic run_load(input logic [2:0] sel, input logic [63:0] addr,
                            input int unsigned delay, input bit pulses);
        int unsigned nb, sz, nreq, exp_lat, ri, w;
        logic [63:0] amask, a, base, off, exp_data;
        logic [63:0] exp_addr [2];
        bit err, sgn, got;
        nb    = cur_bytes();
        amask = cur_mask();
        a     = addr & amask;
        case (sel[1:0])
            2'b00:   sz = 1;
            2'b01:   sz = 2;
            2'b10:   sz = 4;
            default: sz = (nb == 8) ? 8 : 4;
        endcase
        sgn = !sel[2];
        err = (dut_sel == 2'd1) && ((a % 64'(sz)) != 0);
        exp_data = '0;
        if (!err) begin
            for (int unsigned i = 0; i < sz; i++)
                exp_data = exp_data | (64'(mem_byte((a + 64'(i)) & amask)) << (8 * i));
            if (sgn && sz < nb && exp_data[8*sz-1])
                exp_data = exp_data | (amask & ~((64'(1) << (8 * sz)) - 1));
        end
        base        = a & ~64'(nb - 1);
        off         = a - base;
        nreq        = err ? 0 : ((off + 64'(sz) > 64'(nb)) ? 2 : 1);
        exp_addr[0] = base;
        exp_addr[1] = (base + 64'(nb)) & amask;
        exp_lat     = err ? 1 : 1 + nreq * (1 + delay);

        @(negedge clk);
        chk("ready_idle", 64'(ob_ready), 64'd1);
        tb_valid = 1'b1; tb_sel = sel; tb_addr = addr;
        @(negedge clk);
        tb_valid = 1'b0; tb_addr = {$urandom, $urandom}; tb_sel = 3'($urandom);
        got = 1'b0; ri = 0; w = 0;
        for (int unsigned c = 1; c <= 40 && !got; c++) begin
            tb_ack = 1'b0; tb_valid = 1'b0; tb_mdata = {$urandom, $urandom};
            if (ob_valid) begin
                got = 1'b1;
                chk("latency", 64'(c), 64'(exp_lat));
                chk("data", ob_data, exp_data);
                chk("misaligned", 64'(ob_mis), 64'(err));
                chk("req_count", 64'(ri), 64'(nreq));
            end else begin
                chk("ready_busy", 64'(ob_ready), 64'd0);
                chk("req_or_valid", 64'(ob_mem_req), 64'd1);
                if (ob_mem_req) begin
                    chk("req_expected", 64'(ri < nreq), 64'd1);
                    if (ri < nreq) chk("mem_addr", ob_mem_addr, exp_addr[ri]);
                    if (pulses) tb_valid = 1'b1;
                    if (w == delay) begin
                        tb_ack = 1'b1; tb_mdata = mem_word(ob_mem_addr); ri++; w = 0;
                    end else begin
                        w++;
                    end
                end
                @(negedge clk);
            end
        end
        chk("valid_seen", 64'(got), 64'd1);
        tb_ack = 1'b0; tb_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", 64'(ob_valid), 64'd0);
        chk("data_hold", ob_data, exp_data);
        chk("ready_after", 64'(ob_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int unsigned k = 0; k < 3; k++) begin
            dut_sel = 2'(k);
            #1;
            chk("rst_mem_req", 64'(ob_mem_req), 64'd0);
            chk("rst_mem_addr", ob_mem_addr, 64'd0);
            chk("rst_valid", 64'(ob_valid), 64'd0);
            chk("rst_mis", 64'(ob_mis), 64'd0);
            chk("rst_data", ob_data, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        put_bytes(64'h1000, 64'h80FF_1234, 4);
        put_bytes(64'h2000, 64'hAB00_0000, 4);
        put_bytes(64'h2004, 64'h0000_00CD, 4);
        put_bytes(64'h100, 64'h8765_4321_0000_0000, 8);

        dut_sel = 2'd0;
        run_load(3'b000, 64'h1003, 0, 1'b0);
        chk("lb_1003", ob_data, 64'hFFFF_FF80);
        run_load(3'b100, 64'h1003, 0, 1'b0);
        chk("lbu_1003", ob_data, 64'h0000_0080);
        run_load(3'b001, 64'h2003, 0, 1'b0);
        chk("lh_cross", ob_data, 64'hFFFF_CDAB);
        run_load(3'b001, 64'hFFFF_FFFF, 0, 1'b0);
        run_load(3'b001, 64'h1001, 0, 1'b0);
        run_load(3'b010, 64'h1000, 5, 1'b1);
        chk("lw_delay", ob_data, 64'h80FF_1234);

        // Reset while waiting on the second word of a crossing load.
        @(negedge clk);
        tb_valid = 1'b1; tb_sel = 3'b001; tb_addr = 64'h2003;
        @(negedge clk);
        tb_valid = 1'b0; tb_ack = 1'b1; tb_mdata = mem_word(64'h2000);
        @(negedge clk);
        tb_ack = 1'b0;
        chk("req1_req", 64'(ob_mem_req), 64'd1);
        chk("req1_addr", ob_mem_addr, 64'h2004);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_req", 64'(ob_mem_req), 64'd0);
        chk("arst_mem_addr", ob_mem_addr, 64'd0);
        chk("arst_valid", 64'(ob_valid), 64'd0);
        chk("arst_data", ob_data, 64'd0);
        @(negedge clk);
        rst = 1'b0; tb_ack = 1'b1; tb_mdata = mem_word(64'h2004);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_valid", 64'(ob_valid), 64'd0);
            chk("stray_ready", 64'(ob_ready), 64'd1);
        end
        tb_ack = 1'b0;

        for (int unsigned i = 0; i < 40; i++)
            run_load(3'($urandom_range(0, 6)), {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom));

        dut_sel = 2'd1;
        run_load(3'b010, 64'h3002, 0, 1'b0);
        run_load(3'b001, 64'h1001, 0, 1'b0);
        run_load(3'b010, 64'h1000, 1, 1'b0);
        for (int unsigned i = 0; i < 25; i++)
            run_load(3'($urandom_range(0, 6)), {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom));

        dut_sel = 2'd2;
        run_load(3'b110, 64'h104, 0, 1'b0);
        chk("lwu_104", ob_data, 64'h0000_0000_8765_4321);
        run_load(3'b010, 64'h104, 0, 1'b0);
        chk("lw_104", ob_data, 64'hFFFF_FFFF_8765_4321);
        run_load(3'b011, 64'h100, 0, 1'b0);
        chk("ld_100", ob_data, 64'h8765_4321_0000_0000);
        run_load(3'b010, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
        run_load(3'b011, 64'h103, 2, 1'b1);
        for (int unsigned i = 0; i < 40; i++)
            run_load(3'($urandom_range(0, 6)), {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
